// File: rtl/key_press_conditioner.sv
// Pushbutton front-end: synchronizes an active-low key and a switch bank, debounces the key,
// and emits one press_pulse per accepted press (plus optional auto-repeat) with a SW snapshot.
module key_press_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 0,
  parameter int DATA_W          = 10
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              KEY_n,
  input  logic [DATA_W-1:0] SW,
  output logic              press_pulse,
  output logic [DATA_W-1:0] sw_captured,
  output logic              key_held
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST = (REPEAT_CYCLES == 0) ? '0 : CNT_W'(REPEAT_CYCLES - 1);
  localparam bit REPEAT_EN = (REPEAT_CYCLES != 0);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES == 1 || REPEAT_CYCLES < 0) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be 0 or >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic              key_s1;
  logic              key_s;
  logic [DATA_W-1:0] sw_s1;
  logic [DATA_W-1:0] sw_s;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  rcnt;
  logic [CNT_W-1:0]  rcnt_nxt;
  logic              pulse_nxt;

  // NOTE: the key synchronizer resets to "released" so a key held through reset must
  // re-earn a full debounce instead of looking like an instant press.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_s1 <= 1'b1;
      key_s  <= 1'b1;
      sw_s1  <= '0;
      sw_s   <= '0;
    end else begin
      // NOTE: non-blocking assignments make the two flops a true shift chain.
      key_s1 <= KEY_n;
      key_s  <= key_s1;
      sw_s1  <= SW;
      sw_s   <= sw_s1;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    rcnt_nxt  = rcnt;
    pulse_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (!key_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end

      PRESS_WAIT: begin
        if (key_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          rcnt_nxt  = '0;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      PRESSED: begin
        if (key_s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
          rcnt_nxt  = '0;
        end else if (REPEAT_EN) begin
          if (rcnt == REP_LAST) begin
            pulse_nxt = 1'b1;
            rcnt_nxt  = '0;
          end else begin
            rcnt_nxt = rcnt + 1'b1;
          end
        end
      end

      RELEASE_WAIT: begin
        // A short high blip while held is a release bounce: resume holding, no new pulse.
        if (!key_s) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          rcnt_nxt  = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        rcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rcnt        <= '0;
      press_pulse <= 1'b0;
      sw_captured <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      rcnt        <= rcnt_nxt;
      press_pulse <= pulse_nxt;
      if (pulse_nxt) begin
        sw_captured <= sw_s;
      end
    end
  end

  assign key_held = (state == PRESSED) || (state == RELEASE_WAIT);

endmodule

// File: tb/tb_key_press_conditioner.sv
// Self-checking bench: two instances (no repeat / repeat=5) against a run-length behavioural model,
// plus hand-computed literal checks for latency, capture timing, repeat count and async reset.
module tb_key_press_conditioner;

  localparam int D   = 4;
  localparam int REP = 5;
  localparam int W   = 10;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         key_n = 1'b1;
  logic [W-1:0] sw    = '0;

  logic         pulse0, pulse1;
  logic         held0, held1;
  logic [W-1:0] cap0, cap1;

  int n_chk = 0;
  int n_err = 0;
  int pcnt [2] = '{0, 0};
  int base0, base1;

  always #5 clk = ~clk;

  key_press_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(0), .DATA_W(W)) u_norep (
    .CLOCK_50(clk), .reset(reset), .KEY_n(key_n), .SW(sw),
    .press_pulse(pulse0), .sw_captured(cap0), .key_held(held0)
  );

  key_press_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(REP), .DATA_W(W)) u_rep (
    .CLOCK_50(clk), .reset(reset), .KEY_n(key_n), .SW(sw),
    .press_pulse(pulse1), .sw_captured(cap1), .key_held(held1)
  );

  // Model: the accepted key level flips once D+1 consecutive synchronized samples disagree
  // with it; while down and steady, a repeat fires every REP samples.
  typedef struct {
    bit           down;
    int           run;
    int           hold;
    bit           pulse;
    logic [W-1:0] cap;
  } mstate_t;

  mstate_t      ms [2];
  logic [1:0]   key_hist;
  logic [W-1:0] sw_h0, sw_h1;

  function automatic mstate_t step_model(mstate_t s, logic ks, logic [W-1:0] sws, int rep);
    mstate_t n = s;
    n.pulse = 1'b0;
    if (!s.down) begin
      if (ks == 1'b0) begin
        n.run = s.run + 1;
        if (n.run == D + 1) begin
          n.down = 1'b1; n.run = 0; n.hold = 0; n.pulse = 1'b1; n.cap = sws;
        end
      end else begin
        n.run = 0;
      end
    end else if (ks == 1'b1) begin
      n.run = s.run + 1;
      if (n.run == D + 1) begin
        n.down = 1'b0; n.run = 0;
      end
    end else if (s.run != 0) begin
      n.run = 0; n.hold = 0;
    end else if (rep != 0) begin
      n.hold = s.hold + 1;
      if (n.hold == rep) begin
        n.pulse = 1'b1; n.cap = sws; n.hold = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      key_hist <= 2'b11;
      sw_h0    <= '0;
      sw_h1    <= '0;
      for (int i = 0; i < 2; i++) ms[i] <= '{down: 1'b0, run: 0, hold: 0, pulse: 1'b0, cap: '0};
    end else begin
      key_hist <= {key_hist[0], key_n};
      sw_h0    <= sw;
      sw_h1    <= sw_h0;
      ms[0]    <= step_model(ms[0], key_hist[1], sw_h1, 0);
      ms[1]    <= step_model(ms[1], key_hist[1], sw_h1, REP);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("model.norep.pulse", 32'(pulse0), 32'(ms[0].pulse));
      check("model.norep.cap",   32'(cap0),   32'(ms[0].cap));
      check("model.norep.held",  32'(held0),  32'(ms[0].down));
      check("model.rep.pulse",   32'(pulse1), 32'(ms[1].pulse));
      check("model.rep.cap",     32'(cap1),   32'(ms[1].cap));
      check("model.rep.held",    32'(held1),  32'(ms[1].down));
    end
  end

  always @(posedge clk) begin
    #2;
    if (!reset) begin
      if (pulse0) pcnt[0] <= pcnt[0] + 1;
      if (pulse1) pcnt[1] <= pcnt[1] + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1 reset = 1'b1;
    step(2);
    check("reset.pulse", 32'(pulse0), 32'd0);
    check("reset.cap",   32'(cap0),   32'd0);
    check("reset.held",  32'(held1),  32'd0);
    reset = 1'b0;
    step(3);

    // Clean press: pulse after edge 7, release drops key_held after edge 7.
    sw = 10'h155;
    step(3);
    base0 = pcnt[0];
    key_n = 1'b0;
    step(6);
    check("clean.early", 32'(pulse0), 32'd0);
    step(1);
    check("clean.pulse", 32'(pulse0), 32'd1);
    check("clean.cap",   32'(cap0),   32'h155);
    check("clean.held",  32'(held0),  32'd1);
    step(1);
    check("clean.one_wide", 32'(pulse0), 32'd0);
    step(12);
    key_n = 1'b1;
    step(6);
    check("clean.held_before_release", 32'(held0), 32'd1);
    step(1);
    check("clean.released", 32'(held0), 32'd0);
    check("clean.count", 32'(pcnt[0] - base0), 32'd1);
    step(3);

    // Bouncy press, then steady low.
    base0 = pcnt[0];
    key_n = 1'b0; step(2); key_n = 1'b1; step(2);
    key_n = 1'b0; step(2); key_n = 1'b1; step(2);
    key_n = 1'b0; step(1); key_n = 1'b1; step(1);
    key_n = 1'b0;
    step(6);
    check("bounce.none_yet", 32'(pcnt[0] - base0), 32'd0);
    step(1);
    check("bounce.pulse", 32'(pulse0), 32'd1);
    step(5);
    key_n = 1'b1;
    step(10);
    check("bounce.count", 32'(pcnt[0] - base0), 32'd1);

    // Short glitches: 3 and 4 cycles low never accept; 5 cycles does.
    base0 = pcnt[0];
    key_n = 1'b0; step(3); key_n = 1'b1; step(8);
    key_n = 1'b0; step(4); key_n = 1'b1; step(8);
    check("glitch.no_pulse", 32'(pcnt[0] - base0), 32'd0);
    key_n = 1'b0; step(5); key_n = 1'b1; step(12);
    check("glitch.five_accepts", 32'(pcnt[0] - base0), 32'd1);
    check("glitch.idle_again", 32'(held0), 32'd0);

    // Held key with a 2-cycle release blip.
    base0 = pcnt[0];
    key_n = 1'b0; step(8);
    key_n = 1'b1; step(2);
    key_n = 1'b0; step(10);
    check("blip.no_second", 32'(pcnt[0] - base0), 32'd1);
    check("blip.held", 32'(held0), 32'd1);
    key_n = 1'b1; step(10);

    // Capture timing: SW sampled two edges before the pulse edge wins.
    sw = 10'h001;
    step(3);
    key_n = 1'b0; step(4);
    sw = 10'h3FF; step(3);
    check("capture.pulse", 32'(pulse0), 32'd1);
    check("capture.value", 32'(cap0), 32'h3FF);
    sw = 10'h000; step(5);
    check("capture.hold", 32'(cap0), 32'h3FF);
    key_n = 1'b1; step(10);

    // Auto-repeat: 7 pulses from acceptance through 30 more cycles.
    base0 = pcnt[0];
    base1 = pcnt[1];
    key_n = 1'b0; step(7);
    check("repeat.first", 32'(pulse1), 32'd1);
    step(30);
    check("repeat.count", 32'(pcnt[1] - base1), 32'd7);
    check("repeat.disabled", 32'(pcnt[0] - base0), 32'd1);
    key_n = 1'b1; step(10);
    check("repeat.stops", 32'(pcnt[1] - base1), 32'd7);
    check("repeat.released", 32'(held1), 32'd0);

    // Async reset mid-PRESS_WAIT and in PRESSED, key held throughout.
    sw = 10'h2AA;
    step(3);
    key_n = 1'b0; step(4);
    #2 reset = 1'b1;
    #1;
    check("rst1.pulse", 32'(pulse0), 32'd0);
    check("rst1.held",  32'(held0),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    base0 = pcnt[0];
    step(6);
    check("rst1.full_debounce", 32'(pcnt[0] - base0), 32'd0);
    step(1);
    check("rst1.pulse_after", 32'(pulse0), 32'd1);
    check("rst1.cap", 32'(cap0), 32'h2AA);
    #2 reset = 1'b1;
    #1;
    check("rst2.pulse", 32'(pulse0), 32'd0);
    check("rst2.held",  32'(held0),  32'd0);
    check("rst2.cap",   32'(cap0),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    base0 = pcnt[0];
    step(6);
    check("rst2.full_debounce", 32'(pcnt[0] - base0), 32'd0);
    step(1);
    check("rst2.pulse_after", 32'(pulse0), 32'd1);
    step(1);
    check("rst2.single", 32'(pcnt[0] - base0), 32'd1);
    key_n = 1'b1; step(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/key_press_conditioner.md
Name: key_press_conditioner

Overview:
- Upstream front-end for the accumulate stage on the DE-series board.
- Conditions one raw, active-low pushbutton: 2-flop synchronizer, debounce state machine, optional auto-repeat.
- Emits a single-cycle press pulse. On that same edge it captures a synchronized snapshot of the switch bank.
- The accumulator adds the captured value exactly once per physical press, instead of every clock while the key is held.

Parameters:
- DEBOUNCE_CYCLES, 1000000: cycles of stable level required to accept a press or a release (20 ms at 50 MHz). Must be >= 2.
- REPEAT_CYCLES, 0: auto-repeat period while held, in cycles. 0 disables repeat. When nonzero, must be >= 2.
- DATA_W, 10: width of switch input and captured output.

Ports:
- CLOCK_50  input  1  system clock (50 MHz); all state on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- KEY_n  input  1  raw pushbutton, 0 = pressed, asynchronous to clock.
- SW  input  DATA_W  raw switches, asynchronous.
- press_pulse  output  1  one-cycle strobe per accepted press or auto-repeat.
- sw_captured  output  DATA_W  synchronized SW value latched on the edge that raises press_pulse.
- key_held  output  1  high while the debounced key is considered down (states PRESSED and RELEASE_WAIT).

Behaviour:
- Reset (async, immediate):
  - State = IDLE; counters = 0.
  - Key synchronizer flops = 1 (released); SW synchronizer flops = 0.
  - press_pulse = 0, sw_captured = 0, key_held = 0.
  - Reset mid-press aborts the press. After release of reset, a key still held low must pass the full debounce before a pulse.
- Synchronizers: 2 flops each for KEY_n and every SW bit. ks denotes the second key flop.
- Counter width: $clog2 of max(DEBOUNCE_CYCLES, REPEAT_CYCLES) + 1 bits. It never wraps; it is cleared on every state change.
- States and transitions:
  - IDLE: if ks == 0 -> PRESS_WAIT, cnt = 0.
  - PRESS_WAIT:
    - If ks == 1 (bounce) -> IDLE, no pulse.
    - Else if cnt == DEBOUNCE_CYCLES-1 -> PRESSED; press_pulse = 1 and sw_captured = synchronized SW on this edge; rcnt = 0.
    - Else cnt++.
  - PRESSED:
    - If ks == 1 -> RELEASE_WAIT, cnt = 0.
    - Else if REPEAT_CYCLES != 0: rcnt++. When rcnt == REPEAT_CYCLES-1: press_pulse = 1, recapture SW, rcnt = 0.
  - RELEASE_WAIT:
    - If ks == 0 -> PRESSED with no pulse (release bounce); rcnt = 0.
    - Else if cnt == DEBOUNCE_CYCLES-1 -> IDLE.
    - Else cnt++.
- press_pulse is registered and high for exactly one cycle; it is never high two consecutive cycles.
- sw_captured changes only on edges that raise press_pulse; otherwise it holds.
- Latency (clean press): the pulse is high in the cycle following rising edge number DEBOUNCE_CYCLES+3, counting edge 1 as the first edge that samples KEY_n low.
- key_held rises on the same edge as the first pulse. It falls on the edge entering IDLE.
- SW changing during debounce has no effect. Only the value synchronized at the pulse edge is captured, i.e. SW as sampled 2 edges earlier.
- Releases shorter than DEBOUNCE_CYCLES while held produce no extra pulse.
- Presses shorter than DEBOUNCE_CYCLES produce no pulse.

Test Plan:
- Clean press: DEBOUNCE_CYCLES=4, REPEAT_CYCLES=0, SW=10'h155 steady, KEY_n low at edge 1 held 20 cycles -> press_pulse=1 only after edge 7, sw_captured=10'h155, key_held=1. Then release -> key_held=0 exactly 4+3 edges after release is sampled.
- Bouncy press: KEY_n toggles low/high every 2 cycles for 10 cycles, then low steady -> no pulse during bouncing. Exactly one pulse 7 edges after the final low sample.
- Short glitch and release bounce: 3-cycle low glitch with DEBOUNCE=4 -> no pulse. While held, a 2-cycle high blip -> no second pulse, key_held stays 1.
- Capture timing: SW=10'h001 during debounce, changed to 10'h3FF two cycles before the pulse edge -> sw_captured=10'h3FF. SW changed to 10'h000 afterwards -> sw_captured holds 10'h3FF.
- Auto-repeat: REPEAT_CYCLES=5, key held 30 cycles past acceptance -> pulses at acceptance and every 5 cycles thereafter (7 total within the window counting the first, then stop on release), each one cycle wide.
- Async reset: assert reset mid-PRESS_WAIT and again in PRESSED, between clock edges -> outputs 0 immediately. With key still held after deassertion -> new full 7-edge debounce before a single pulse.
